// File: rtl/conv_bram_1d_pad_dil.sv
// conv_bram_1d_pad_dil: BRAM-fed 1D convolution with zero padding, dilation and stride.
// One filter tap is issued per cycle; all input and output channels run in parallel.
module conv_bram_1d_pad_dil #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int IMG_D      = 4,
   parameter int FILTER_L   = 3,
   parameter int RESULT_D   = 4,
   parameter int STRIDE_W   = 1,
   parameter int DIL_W      = 1,
   parameter int PAD_W      = 0,
   parameter int ACC_WIDTH  = 4*DATA_WIDTH,
   localparam int RESULT_W  = (IMG_W+2*PAD_W-DIL_W*(FILTER_L-1)-1)/STRIDE_W+1,
   localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W),
   localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [DATA_WIDTH*RESULT_D*IMG_D*FILTER_L-1:0] fil,
   input  logic                                         val_in,
   output logic                                         rdy_in,
   output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0]          img_rdaddr,
   input  logic [DATA_WIDTH*IMG_D-1:0]                  img_rddata,
   output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0]    result_wraddr,
   output logic [ACC_WIDTH*RESULT_D-1:0]                result_wrdata,
   output logic [RESULT_D-1:0]                          result_wren,
   output logic                                         done
);
   localparam int FIL_BITS = DATA_WIDTH*RESULT_D*IMG_D*FILTER_L;
   localparam int XW       = $clog2(RESULT_W) + 1;
   localparam int LW       = $clog2(FILTER_L) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;

   logic [FIL_BITS-1:0] fil_q;

   // stage p0: tap currently presented on img_rdaddr
   logic                          vld_p0, pad_p0;
   logic [XW-1:0]                 x_p0;
   logic [LW-1:0]                 l_p0;
   logic [IMG_RAM_ADDR_WIDTH-1:0] addr_p0;

   // stage p1: BRAM data for the p0 tap is on img_rddata
   logic          vld_p1, pad_p1;
   logic [XW-1:0] x_p1;
   logic [LW-1:0] l_p1;

   logic signed [ACC_WIDTH-1:0]      acc    [RESULT_D];
   logic signed [ACC_WIDTH-1:0]      acc_nx [RESULT_D];
   logic                             wren_q, final_q;
   logic [RESULT_RAM_ADDR_WIDTH-1:0] wraddr_q;

   logic [XW-1:0] x_is;
   logic [LW-1:0] l_is;
   int            p_is;
   logic          in_rng, last_tap, issue;

   // Image position of tap l of output x; negative or >= IMG_W lands in the padding.
   function automatic int tap_pos(input logic [XW-1:0] x, input logic [LW-1:0] l);
      return int'(x)*STRIDE_W + int'(l)*DIL_W - PAD_W;
   endfunction

   // Signed full-precision product, sign-extended to the accumulator width.
   function automatic logic signed [ACC_WIDTH-1:0] mul_ext(input logic signed [DATA_WIDTH-1:0] a,
                                                           input logic signed [DATA_WIDTH-1:0] b);
      logic signed [2*DATA_WIDTH-1:0] prod;
      prod = a * b;
      return ACC_WIDTH'(prod);
   endfunction

   // Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
   function automatic logic signed [ACC_WIDTH-1:0] wrap_add(input logic signed [ACC_WIDTH-1:0] a,
                                                            input logic signed [ACC_WIDTH-1:0] b);
      return a + b;
   endfunction

   // Next tap to issue: tap (0,0) on accept, otherwise step l then x.
   always_comb begin
      last_tap = (x_p0 == XW'(RESULT_W-1)) && (l_p0 == LW'(FILTER_L-1));
      if (state == IDLE) begin
         x_is = '0;
         l_is = '0;
      end else if (l_p0 == LW'(FILTER_L-1)) begin
         x_is = x_p0 + XW'(1);
         l_is = '0;
      end else begin
         x_is = x_p0;
         l_is = l_p0 + LW'(1);
      end
      p_is   = tap_pos(x_is, l_is);
      in_rng = (p_is >= 0) && (p_is < IMG_W);
      issue  = ((state == IDLE) && val_in && rdy_in) || ((state == RUN) && !last_tap);
   end

   // Control FSM, filter latch and tap issue (stage p0 registers).
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rdy_in  <= 1'b1;
         done    <= 1'b0;
         vld_p0  <= 1'b0;
         pad_p0  <= 1'b0;
         addr_p0 <= '0;
      end else begin
         done <= 1'b0;
         if (issue) begin
            vld_p0  <= 1'b1;
            x_p0    <= x_is;
            l_p0    <= l_is;
            pad_p0  <= !in_rng;
            addr_p0 <= in_rng ? p_is[IMG_RAM_ADDR_WIDTH-1:0] : '0;
         end else begin
            vld_p0  <= 1'b0;
            pad_p0  <= 1'b0;
            addr_p0 <= '0;
         end
         case (state)
            IDLE: if (val_in && rdy_in) begin
               fil_q  <= fil;
               rdy_in <= 1'b0;
               state  <= RUN;
            end
            RUN: if (last_tap) state <= DRAIN;
            DRAIN: if (wren_q && final_q) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state  <= IDLE;
               rdy_in <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Multiply-accumulate of the returning tap; padded taps contribute zero.
   always_comb begin
      for (int k = 0; k < RESULT_D; k++) begin
         acc_nx[k] = (l_p1 == '0) ? '0 : acc[k];
         for (int d = 0; d < IMG_D; d++) begin
            if (!pad_p1)
               acc_nx[k] = wrap_add(acc_nx[k],
                  mul_ext(fil_q[((k*IMG_D+d)*FILTER_L + int'(l_p1))*DATA_WIDTH +: DATA_WIDTH],
                          img_rddata[d*DATA_WIDTH +: DATA_WIDTH]));
         end
      end
   end

   // Stage p1 registers, accumulators and result write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1        <= 1'b0;
         pad_p1        <= 1'b0;
         wren_q        <= 1'b0;
         final_q       <= 1'b0;
         wraddr_q      <= '0;
         result_wrdata <= '0;
         for (int k = 0; k < RESULT_D; k++) acc[k] <= '0;
      end else begin
         vld_p1  <= vld_p0;
         pad_p1  <= pad_p0;
         x_p1    <= x_p0;
         l_p1    <= l_p0;
         wren_q  <= vld_p1 && (l_p1 == LW'(FILTER_L-1));
         final_q <= vld_p1 && (l_p1 == LW'(FILTER_L-1)) && (x_p1 == XW'(RESULT_W-1));
         if (vld_p1) begin
            for (int k = 0; k < RESULT_D; k++) acc[k] <= acc_nx[k];
            if (l_p1 == LW'(FILTER_L-1)) begin
               wraddr_q <= x_p1[RESULT_RAM_ADDR_WIDTH-1:0];
               for (int k = 0; k < RESULT_D; k++)
                  result_wrdata[k*ACC_WIDTH +: ACC_WIDTH] <= acc_nx[k];
            end
         end
      end
   end

   assign img_rdaddr    = {IMG_D{addr_p0}};
   assign result_wraddr = {RESULT_D{wraddr_q}};
   assign result_wren   = {RESULT_D{wren_q}};

endmodule

// File: tb/tb_conv_bram_1d_pad_dil.sv
// Testbench for conv_bram_1d_pad_dil: a dense single-channel instance (u0) and a
// two-channel padded/dilated/strided instance (u1), checked against a plain-arithmetic model.
module tb_conv_bram_1d_pad_dil;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0, errors = 0;

   // u0: IMG_W=8, IMG_D=1, FILTER_L=3, RESULT_D=1, dense, ACC 32 -> RESULT_W=6
   logic [23:0] fil0 = '0;
   logic        val0 = 1'b0, rdy0, done0;
   logic [2:0]  addr0, wa0;
   logic [7:0]  rd0;
   logic [31:0] wd0;
   logic [0:0]  we0;
   conv_bram_1d_pad_dil #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(1), .FILTER_L(3), .RESULT_D(1))
      u0 (.clk(clk), .reset(reset), .fil(fil0), .val_in(val0), .rdy_in(rdy0),
          .img_rdaddr(addr0), .img_rddata(rd0), .result_wraddr(wa0),
          .result_wrdata(wd0), .result_wren(we0), .done(done0));

   // u1: IMG_W=8, IMG_D=2, RESULT_D=2, S=2, DIL=2, PAD=1, ACC 16 -> RESULT_W=3
   logic [95:0] fil1 = '0;
   logic        val1 = 1'b0, rdy1, done1;
   logic [5:0]  addr1;
   logic [15:0] rd1;
   logic [3:0]  wa1;
   logic [31:0] wd1;
   logic [1:0]  we1;
   conv_bram_1d_pad_dil #(.DATA_WIDTH(8), .IMG_W(8), .IMG_D(2), .FILTER_L(3), .RESULT_D(2),
                          .STRIDE_W(2), .DIL_W(2), .PAD_W(1), .ACC_WIDTH(16))
      u1 (.clk(clk), .reset(reset), .fil(fil1), .val_in(val1), .rdy_in(rdy1),
          .img_rdaddr(addr1), .img_rddata(rd1), .result_wraddr(wa1),
          .result_wrdata(wd1), .result_wren(we1), .done(done1));

   // BRAM models, 1-cycle read latency
   logic [7:0] img0 [8];
   logic [7:0] img1 [2][8];
   always @(posedge clk) rd0 <= img0[addr0];
   always @(posedge clk) rd1 <= {img1[1][addr1[5:3]], img1[0][addr1[2:0]]};

   // write/done monitors, sampled on the falling edge
   int         w0_cyc[$]; logic [2:0] w0_addr[$]; logic [31:0] w0_data[$]; int d0_cyc[$];
   int         w1_cyc[$]; logic [3:0] w1_addr[$]; logic [31:0] w1_data[$]; logic [1:0] w1_we[$];
   int         d1_cyc[$];
   always @(negedge clk) begin
      if (we0 !== 1'b0) begin w0_cyc.push_back(cyc); w0_addr.push_back(wa0); w0_data.push_back(wd0); end
      if (done0 !== 1'b0) d0_cyc.push_back(cyc);
      if (we1 !== 2'b00) begin
         w1_cyc.push_back(cyc); w1_addr.push_back(wa1); w1_data.push_back(wd1); w1_we.push_back(we1);
      end
      if (done1 !== 1'b0) d1_cyc.push_back(cyc);
   end

   // reference model: m_img[d][p], m_fil[k][d][l]
   int m_img [2][8];
   int m_fil [2][2][3];

   function automatic logic [31:0] model(int x, int k, int nd, int s, int dil, int pad, int aw);
      longint sum = 0;
      logic [31:0] r;
      for (int l = 0; l < 3; l++) begin
         int p;
         p = x*s + l*dil - pad;
         if (p >= 0 && p < 8)
            for (int d = 0; d < nd; d++) sum += longint'(m_fil[k][d][l]) * longint'(m_img[d][p]);
      end
      r = 32'(sum);
      if (aw < 32) r = r & ((32'd1 << aw) - 32'd1);
      return r;
   endfunction

   task automatic load_all();
      for (int p = 0; p < 8; p++) begin
         img0[p]    = 8'(m_img[0][p]);
         img1[0][p] = 8'(m_img[0][p]);
         img1[1][p] = 8'(m_img[1][p]);
      end
      for (int l = 0; l < 3; l++) fil0[l*8 +: 8] = 8'(m_fil[0][0][l]);
      for (int k = 0; k < 2; k++)
         for (int d = 0; d < 2; d++)
            for (int l = 0; l < 3; l++) fil1[((k*2+d)*3+l)*8 +: 8] = 8'(m_fil[k][d][l]);
   endtask

   task automatic set_basic();
      for (int p = 0; p < 8; p++) m_img[0][p] = p + 1;
      for (int l = 0; l < 3; l++) m_fil[0][0][l] = 1;
      load_all();
   endtask

   task automatic rand_model();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 8; p++) m_img[d][p] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < 2; k++)
         for (int d = 0; d < 2; d++)
            for (int l = 0; l < 3; l++) m_fil[k][d][l] = int'($urandom_range(255)) - 128;
      load_all();
   endtask

   task automatic clear_q();
      w0_cyc.delete(); w0_addr.delete(); w0_data.delete(); d0_cyc.delete();
      w1_cyc.delete(); w1_addr.delete(); w1_data.delete(); w1_we.delete(); d1_cyc.delete();
   endtask

   // returns at the falling edge of cycle a+1, a = accept cycle (-1 if never accepted)
   task automatic start0(output int a);
      a = -1;
      @(negedge clk); val0 = 1'b1;
      for (int i = 0; i < 10 && a < 0; i++) begin
         if (rdy0 === 1'b1) a = cyc;
         @(negedge clk);
      end
      val0 = 1'b0;
      checks++;
      if (a < 0) begin errors++; $display("FAIL start0 rdy_in=%b never 1 (want 1)", rdy0); end
   endtask

   task automatic start1(output int a);
      a = -1;
      @(negedge clk); val1 = 1'b1;
      for (int i = 0; i < 10 && a < 0; i++) begin
         if (rdy1 === 1'b1) a = cyc;
         @(negedge clk);
      end
      val1 = 1'b0;
      checks++;
      if (a < 0) begin errors++; $display("FAIL start1 rdy_in=%b never 1 (want 1)", rdy1); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_rdy0 got %b want 1", rdy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done0 got %b want 0", done0); end
      checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL rst_we0 got %b want 0", we0); end
      checks++; if (addr0 !== 3'd0 || wa0 !== 3'd0) begin
         errors++; $display("FAIL rst_addr0 got %0d/%0d want 0/0", addr0, wa0); end
      checks++; if (wd0 !== 32'd0) begin errors++; $display("FAIL rst_wd0 got %h want 0", wd0); end
      checks++; if (rdy1 !== 1'b1 || done1 !== 1'b0) begin
         errors++; $display("FAIL rst_ctl1 got rdy=%b done=%b want 1/0", rdy1, done1); end
      checks++; if (we1 !== 2'b00 || wd1 !== 32'd0 || addr1 !== 6'd0 || wa1 !== 4'd0) begin
         errors++; $display("FAIL rst_out1 got we=%b wd=%h a=%h wa=%h want 0", we1, wd1, addr1, wa1); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int a;
      int exp_b[6] = '{6, 9, 12, 15, 18, 21};
      set_basic(); clear_q();
      start0(a);
      repeat (30) @(negedge clk);
      checks++; if (w0_cyc.size() != 6) begin
         errors++; $display("FAIL basic_count got %0d want 6", w0_cyc.size()); end
      for (int x = 0; x < 6; x++) begin
         checks++;
         if (x >= w0_cyc.size()) begin errors++; $display("FAIL basic_missing x=%0d", x); end
         else if (w0_data[x] !== 32'(exp_b[x]) || w0_addr[x] !== 3'(x) || w0_cyc[x] != a+5+3*x) begin
            errors++;
            $display("FAIL basic_wr x=%0d got d=%0d a=%0d c=%0d want d=%0d a=%0d c=%0d",
                     x, w0_data[x], w0_addr[x], w0_cyc[x]-a, exp_b[x], x, 5+3*x);
         end
      end
      checks++; if (d0_cyc.size() != 1 || d0_cyc[0] != a+21) begin
         errors++; $display("FAIL basic_done got n=%0d want one pulse at cycle 21", d0_cyc.size()); end
   endtask

   task automatic test_random_dense();
      int a;
      for (int it = 0; it < 3; it++) begin
         rand_model(); clear_q();
         start0(a);
         repeat (30) @(negedge clk);
         checks++; if (w0_cyc.size() != 6 || d0_cyc.size() != 1) begin
            errors++; $display("FAIL rnd0_count got w=%0d d=%0d want 6/1", w0_cyc.size(), d0_cyc.size()); end
         for (int x = 0; x < 6 && x < w0_cyc.size(); x++) begin
            logic [31:0] e;
            e = model(x, 0, 1, 1, 1, 0, 32);
            checks++;
            if (w0_data[x] !== e || w0_addr[x] !== 3'(x) || w0_cyc[x] != a+5+3*x) begin
               errors++;
               $display("FAIL rnd0_wr it=%0d x=%0d got %h@%0d want %h@%0d", it, x, w0_data[x], w0_addr[x], e, x);
            end
         end
      end
   endtask

   task automatic test_multichan();
      int a;
      logic [15:0] e0[3] = '{16'h0000, 16'h8000, 16'h8000};
      logic [15:0] e1[3] = '{16'hFE00, 16'hFD00, 16'hFD00};
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 8; p++) m_img[d][p] = -128;
         for (int l = 0; l < 3; l++) begin m_fil[0][d][l] = -128; m_fil[1][d][l] = 1; end
      end
      load_all(); clear_q();
      start1(a);
      // taps of output 0 sit at positions -1 (padded), 1, 3
      checks++; if (addr1 !== 6'o00) begin errors++; $display("FAIL pad_addr got %o want 00", addr1); end
      @(negedge clk);
      checks++; if (addr1 !== 6'o11) begin errors++; $display("FAIL tap1_addr got %o want 11", addr1); end
      @(negedge clk);
      checks++; if (addr1 !== 6'o33) begin errors++; $display("FAIL tap2_addr got %o want 33", addr1); end
      repeat (20) @(negedge clk);
      checks++; if (w1_cyc.size() != 3) begin
         errors++; $display("FAIL mc_count got %0d want 3", w1_cyc.size()); end
      for (int x = 0; x < 3 && x < w1_cyc.size(); x++) begin
         checks++;
         if (w1_data[x] !== {e1[x], e0[x]} || w1_we[x] !== 2'b11 || w1_addr[x] !== {2'(x), 2'(x)}
             || w1_cyc[x] != a+5+3*x) begin
            errors++;
            $display("FAIL mc_wr x=%0d got d=%h we=%b a=%h want d=%h%h we=11", x, w1_data[x], w1_we[x],
                     w1_addr[x], e1[x], e0[x]);
         end
      end
      checks++; if (d1_cyc.size() != 1 || d1_cyc[0] != a+12) begin
         errors++; $display("FAIL mc_done got n=%0d want one pulse at cycle 12", d1_cyc.size()); end
   endtask

   task automatic test_random_padded();
      int a;
      for (int it = 0; it < 4; it++) begin
         rand_model(); clear_q();
         start1(a);
         repeat (20) @(negedge clk);
         checks++; if (w1_cyc.size() != 3 || d1_cyc.size() != 1) begin
            errors++; $display("FAIL rnd1_count got w=%0d d=%0d want 3/1", w1_cyc.size(), d1_cyc.size()); end
         for (int x = 0; x < 3 && x < w1_cyc.size(); x++) begin
            logic [31:0] e;
            e = {model(x, 1, 2, 2, 2, 1, 16)[15:0], model(x, 0, 2, 2, 2, 1, 16)[15:0]};
            checks++;
            if (w1_data[x] !== e || w1_we[x] !== 2'b11 || w1_cyc[x] != a+5+3*x) begin
               errors++; $display("FAIL rnd1_wr it=%0d x=%0d got %h want %h", it, x, w1_data[x], e);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int a, late;
      set_basic(); clear_q();
      start0(a);
      while (cyc < a+7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (rdy0 !== 1'b1 || we0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 3'd0 || wd0 !== 32'd0) begin
         errors++; $display("FAIL mid_rst_state got rdy=%b we=%b done=%b a=%0d wd=%h want 1/0/0/0/0",
                            rdy0, we0, done0, addr0, wd0); end
      repeat (25) @(negedge clk);
      late = 0;
      foreach (w0_cyc[i]) if (w0_cyc[i] > a+7) late++;
      checks++; if (late != 0 || w0_cyc.size() != 1) begin
         errors++; $display("FAIL mid_rst_writes got late=%0d total=%0d want 0/1", late, w0_cyc.size()); end
      checks++; if (d0_cyc.size() != 0) begin
         errors++; $display("FAIL mid_rst_done got %0d pulses want 0", d0_cyc.size()); end
      clear_q();
      start0(a);
      repeat (30) @(negedge clk);
      checks++; if (w0_cyc.size() != 6 || d0_cyc.size() != 1) begin
         errors++; $display("FAIL rerun_count got w=%0d d=%0d want 6/1", w0_cyc.size(), d0_cyc.size()); end
      for (int x = 0; x < 6 && x < w0_cyc.size(); x++) begin
         checks++;
         if (w0_data[x] !== 32'(3*x+6) || w0_cyc[x] != a+5+3*x) begin
            errors++; $display("FAIL rerun_wr x=%0d got %0d want %0d", x, w0_data[x], 3*x+6);
         end
      end
   endtask

   task automatic test_back_to_back();
      int a;
      set_basic(); clear_q();
      a = -1;
      @(negedge clk); val0 = 1'b1;
      for (int i = 0; i < 10 && a < 0; i++) begin
         if (rdy0 === 1'b1) a = cyc;
         else @(negedge clk);
      end
      checks++;
      if (a < 0) begin errors++; $display("FAIL b2b_accept rdy_in never 1 (want 1)"); val0 = 1'b0; return; end
      for (int c = a+1; c <= a+43; c++) begin
         logic er;
         @(negedge clk);
         if (c == a+10) begin
            m_fil[0][0][0] = 2; m_fil[0][0][1] = 0; m_fil[0][0][2] = -1;
            load_all();
         end
         er = (c == a+22);
         checks++;
         if (rdy0 !== er) begin errors++; $display("FAIL b2b_rdy cycle=%0d got %b want %b", c-a, rdy0, er); end
      end
      val0 = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (w0_cyc.size() != 12) begin
         errors++; $display("FAIL b2b_count got %0d want 12", w0_cyc.size()); end
      for (int x = 0; x < 6 && x + 6 < w0_cyc.size(); x++) begin
         logic [31:0] e;
         e = model(x, 0, 1, 1, 1, 0, 32);
         checks++;
         if (w0_data[x] !== 32'(3*x+6) || w0_cyc[x] != a+5+3*x) begin
            errors++; $display("FAIL b2b_run1 x=%0d got %0d want %0d", x, w0_data[x], 3*x+6);
         end
         checks++;
         if (w0_data[x+6] !== e || w0_cyc[x+6] != a+27+3*x) begin
            errors++; $display("FAIL b2b_run2 x=%0d got %h want %h", x, w0_data[x+6], e);
         end
      end
      checks++; if (d0_cyc.size() != 2 || d0_cyc[0] != a+21 || d0_cyc[1] != a+43) begin
         errors++; $display("FAIL b2b_done got n=%0d want pulses at 21 and 43", d0_cyc.size()); end
   endtask

   initial begin
      for (int p = 0; p < 8; p++) begin img0[p] = '0; img1[0][p] = '0; img1[1][p] = '0; end
      test_reset();
      test_basic();
      test_random_dense();
      test_multichan();
      test_random_padded();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/conv_bram_1d_pad_dil.md
Name: conv_bram_1d_pad_dil

Overview:
- Next-generation 1D convolution engine that reads an IMG_D-channel image from BRAM and writes RESULT_D output channels to a result BRAM.
- Generalises the current 1D conv block with:
  - zero padding, dilation and stride;
  - signed arithmetic with a configurable accumulator width;
  - an explicit done pulse.
- Computes one filter tap per cycle, across all input and output channels in parallel.
- Sits between the filter-load handshake and the image/result RAM banks of the conv layer.

Parameters:
- DATA_WIDTH, 8, signed image/filter element width.
- IMG_W, 32, image width in pixels.
- IMG_D, 4, input channels.
- FILTER_L, 3, filter taps.
- RESULT_D, 4, output channels (= number of filters).
- STRIDE_W, 1, output stride.
- DIL_W, 1, tap dilation (1 = dense).
- PAD_W, 0, zero pixels on each side.
- ACC_WIDTH, 4*DATA_WIDTH, signed accumulator/result width.
- RESULT_W, (IMG_W+2*PAD_W-DIL_W*(FILTER_L-1)-1)/STRIDE_W+1, derived; not set manually.
- IMG_RAM_ADDR_WIDTH, $clog2(IMG_W), derived.
- RESULT_RAM_ADDR_WIDTH, $clog2(RESULT_W), derived.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- fil  in  DATA_WIDTH*RESULT_D*IMG_D*FILTER_L  filter bank; element (k,d,l) at bits [((k*IMG_D+d)*FILTER_L+l)*DATA_WIDTH +: DATA_WIDTH].
- val_in  in  1  filter valid / start.
- rdy_in  out  1  ready to accept a filter.
- img_rdaddr  out  IMG_RAM_ADDR_WIDTH*IMG_D  read address, identical copy per channel bank.
- img_rddata  in  DATA_WIDTH*IMG_D  channel d at [d*DATA_WIDTH +: DATA_WIDTH]; 1-cycle BRAM read latency.
- result_wraddr  out  RESULT_RAM_ADDR_WIDTH*RESULT_D  write address, identical copy per channel bank.
- result_wrdata  out  ACC_WIDTH*RESULT_D  channel k at [k*ACC_WIDTH +: ACC_WIDTH].
- result_wren  out  RESULT_D  write enable; all bits equal.
- done  out  1  one-cycle pulse when the final result has been written.

Behaviour:
- Reset values:
  - rdy_in=1.
  - done=0.
  - result_wren=0.
  - img_rdaddr=0, result_wraddr=0, result_wrdata=0.
  - FSM in IDLE; accumulators cleared.
- Handshake:
  - A run starts on a cycle with val_in && rdy_in (cycle 0); fil is latched internally that cycle.
  - rdy_in=1 only in IDLE.
  - val_in while busy is ignored.
- FSM: IDLE -> RUN (on accept) -> DRAIN (after last tap issued) -> DONE (1 cycle, done=1) -> IDLE.
  - rdy_in is high again in the cycle after DONE.
- Tap issue:
  - RUN issues tap l of output x at cycle 1 + x*FILTER_L + l, for x = 0..RESULT_W-1 and l = 0..FILTER_L-1.
  - Position p = x*STRIDE_W + l*DIL_W - PAD_W (signed).
  - If 0 <= p < IMG_W: img_rdaddr = p.
  - Otherwise: img_rdaddr = 0, and a pipelined pad flag forces that tap's data to zero on return.
- Arithmetic:
  - Each product is signed DATA_WIDTH x DATA_WIDTH, sign-extended to ACC_WIDTH.
  - acc[k] += sum over d of fil(k,d,l)*img(d), modulo 2^ACC_WIDTH (wrap, no saturation).
  - The accumulator restarts on tap 0 of each output.
- Write:
  - Output x is written at cycle x*FILTER_L + FILTER_L + 2.
  - result_wren=all 1s for exactly one cycle, result_wraddr=x, result_wrdata = the final acc values.
  - Outputs are written in order with no gaps other than the FILTER_L cadence; result_wren is low otherwise.
- done:
  - Pulses in the cycle after the last write (x = RESULT_W-1).
  - One run = RESULT_W*FILTER_L + 3 cycles from accept to done.
- Reset mid-run:
  - Aborts immediately; all outputs return to reset values on the next edge.
  - No further writes; no done pulse.
- Simultaneous done and val_in: not accepted, since rdy_in=0 in DONE; accepted on the next cycle if still asserted.
- img_rddata is sampled only in the cycle after each tap issue; other values are don't-care.

Test Plan:
1. Basic run. IMG_W=8, IMG_D=1, FILTER_L=3, RESULT_D=1, S=1, DIL=1, PAD=0, image 1..8, filter (1,1,1).
   - Required: writes 6, 9, 12, 15, 18, 21 to addresses 0..5.
   - First write at cycle 5; done at cycle 21 after accept.
2. Padding. Same as scenario 1 with PAD_W=1.
   - Required: RESULT_W=8; writes 3, 6, 9, 12, 15, 18, 21, 15.
   - Padded taps read address 0 but contribute 0.
3. Dilation and stride.
   - DIL_W=2, S=1: writes 9, 12, 15, 18 (RESULT_W=4).
   - DIL_W=1, S=2: writes 6, 12, 18 at addresses 0, 1, 2.
4. Multi-channel with signed wrap. IMG_D=2, RESULT_D=2, ACC_WIDTH=16, both image channels all -128.
   - Filter 0: all -128. Required: channel 0 result = 6*16384 mod 2^16 = 0x8000 (-32768).
   - Filter 1: all +1. Required: channel 1 result = -768.
   - result_wren = 2'b11 on every write.
5. Reset mid-run. Assert reset at cycle 7 of the scenario 1 run.
   - Required: no writes after cycle 7, no done, rdy_in=1 next cycle.
   - A new run then produces the scenario 1 results exactly.
6. Busy handshake. Hold val_in=1 continuously.
   - Required: rdy_in=0 from cycle 1 until the cycle after done.
   - Second run accepted exactly one cycle after the done pulse; fil changes mid-run do not affect results.
